// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
//   through a single full-adder stage and a carry flip-flop. A start/busy/done
//   handshake lets slow board-level logic drive it without a long ripple chain.
//
//   Build option: define SERIAL_ADDER_SUB_EN to enable subtract mode (sub=1
//   at the start edge computes A-B). Without it, the sub port is ignored and
//   the block always computes A+B+cin.
//
// Ports:
//   clk       in   system clock, rising-edge
//   reset     in   asynchronous active-high reset
//   start     in   begin an operation (accepted in IDLE or DONE)
//   a, b      in   operands, sampled only on the accepting edge
//   cin       in   carry-in, sampled only on the accepting edge
//   sub       in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy      out  high while the serial addition is running
//   done      out  one-cycle pulse when sum/cout/overflow are updated
//   sum       out  result register
//   cout      out  carry-out of the MSB (no-borrow flag when subtracting)
//   overflow  out  two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter needs at least one bit even for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last_bit;
    logic             sum_bit;
    logic             carry_out;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic [WIDTH-1:0] res_shift;

    // Operand B and initial carry as loaded on the accepting edge.
`ifdef SERIAL_ADDER_SUB_EN
    // A-B = A + ~B + 1; cin is ignored while subtracting.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_bit = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));

    // The single full-adder stage.
    assign sum_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign carry_out = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

    // New sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at LSB.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = sum_bit;
        end else begin : g_res_wn
            assign res_shift = {sum_bit, res_q[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy     = (state_q == S_RUN);
        done     = (state_q == S_DONE);
        sum      = sum_q;
        cout     = cout_q;
        overflow = ovf_q;
    end

    // Datapath next-state
    always_comb begin
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_sr_d  = a;
            b_sr_d  = b_load;
            carry_d = carry_load;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            res_d   = res_shift;
            carry_d = carry_out;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
                // carry_q here is the carry into the MSB.
                sum_d  = res_shift;
                cout_d = carry_out;
                ovf_d  = carry_q ^ carry_out;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
